lsu: RTL and testbench
======================

Name: lsu

Overview:
- Per-thread load/store unit that consumes register-file read operands (rs = address, rt = store data).
- Performs one handshaked transaction with the data-memory controller per instruction.
- Returns load data as lsu_out for the register file's MEMORY writeback in the UPDATE stage.
- One instance per thread; the core scheduler reads lsu_state to know when every thread's memory access has completed.

Parameters:
- data_bits, 8, width of register/memory data.
- addr_bits, 8, width of data-memory address; rs is zero-extended or truncated to this width.
- TIMEOUT_CYCLES, 255, WAITING-state cycles before abort (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  thread active; when low all state holds
- core_state  in  3  core FSM state (REQUEST=3'b011, UPDATE=3'b110)
- dec_mem_read_en  in  1  instruction is LDR
- dec_mem_write_en  in  1  instruction is STR
- rs  in  data_bits  address operand
- rt  in  data_bits  store data operand
- mem_read_valid  out  1  read request
- mem_read_address  out  addr_bits  read address
- mem_read_ready  in  1  read data returned
- mem_read_data  in  data_bits  read data
- mem_write_valid  out  1  write request
- mem_write_address  out  addr_bits  write address
- mem_write_data  out  data_bits  write data
- mem_write_ready  in  1  write accepted
- lsu_state  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11
- lsu_out  out  data_bits  last load result
- lsu_error  out  1  last access aborted by timeout

Behaviour:
- Reset (async): lsu_state=IDLE; all valids, addresses, write data, lsu_out and lsu_error = 0.
- enable low: no state or output changes; valids are held as-is.
- IDLE:
  - If core_state==REQUEST and dec_mem_read_en, go to REQUESTING (read op latched).
  - Else if core_state==REQUEST and dec_mem_write_en, go to REQUESTING (write op latched).
  - Read wins if both enables are set; the write is ignored. Neither set: stay IDLE.
- REQUESTING (one cycle):
  - Read: mem_read_valid<=1, mem_read_address<=rs[addr_bits-1:0].
  - Write: mem_write_valid<=1, mem_write_address<=rs, mem_write_data<=rt.
  - Then go to WAITING.
- WAITING:
  - Valid, address and data are held stable until the matching ready is sampled high.
  - Read + mem_read_ready: mem_read_valid<=0, lsu_out<=mem_read_data, go to DONE.
  - Write + mem_write_ready: mem_write_valid<=0, go to DONE; lsu_out is unchanged.
  - Ready of the non-active channel is ignored.
- DONE: hold until core_state==UPDATE, then go to IDLE. lsu_out stays valid through UPDATE.
- Minimum latency: REQUEST edge, then REQUESTING edge, then first WAITING edge with ready. DONE is reached at the 3rd clock edge.
- A single-cycle ready arriving on the first WAITING cycle is accepted.
- A ready pulse asserted while in REQUESTING is not captured.
- lsu_error clears on the IDLE→REQUESTING transition.
- Reset mid-transaction: the valid drops immediately (asynchronously); the memory side must tolerate an abandoned request.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering WAITING and increments each enabled WAITING cycle.
  - When it reaches TIMEOUT_CYCLES without ready: drop the valid, lsu_error<=1, lsu_out<=0 for reads, go to DONE.
  - Ready arriving on the same cycle as the terminal count wins: normal completion, no error.
- Not defined: no counter; WAITING lasts indefinitely; lsu_error is constant 0.

Decomposition:
- Shared package gpu_pkg:
  - core_state_t enum (IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE = 0..7).
  - lsu_state_t enum (IDLE, REQUESTING, WAITING, DONE).
  - Constant CORE_REQUEST/CORE_UPDATE aliases.
- Single flat module; no sub-module is warranted (the timeout counter is a few lines under the macro).

Test Plan:
- Load: rs=8'h2A, read_en, core_state REQUEST; ready+data 8'h5C two cycles after valid → mem_read_address=8'h2A, lsu_out=8'h5C, lsu_state DONE, IDLE after UPDATE.
- Store: rs=8'h10, rt=8'hA5, write_en; ready after 4 cycles → write valid/address/data held constant 4 cycles, drop on ready, lsu_out unchanged.
- Both enables set → only mem_read_valid asserts; mem_write_valid stays 0 throughout.
- enable low for 3 cycles while WAITING with ready high → no capture; capture on the first enabled cycle.
- Async reset mid-WAITING → valid and lsu_state drop to 0 before the next clock edge.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted → DONE after 4 WAITING cycles, lsu_error=1, lsu_out=0; the next load clears lsu_error.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU core types: core FSM encoding and per-thread LSU state encoding.
package gpu_pkg;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_FETCH   = 3'd1,
    CS_DECODE  = 3'd2,
    CS_REQUEST = 3'd3,
    CS_WAIT    = 3'd4,
    CS_EXECUTE = 3'd5,
    CS_UPDATE  = 3'd6,
    CS_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = CS_REQUEST;
  localparam logic [2:0] CORE_UPDATE  = CS_UPDATE;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: one handshaked data-memory access per LDR/STR.
// Optional WAITING-state timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu
  import gpu_pkg::*;
#(
  parameter int unsigned data_bits      = 8,
  parameter int unsigned addr_bits      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 dec_mem_read_en,
  input  logic                 dec_mem_write_en,
  input  logic [data_bits-1:0] rs,
  input  logic [data_bits-1:0] rt,
  output logic                 mem_read_valid,
  output logic [addr_bits-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [data_bits-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [addr_bits-1:0] mem_write_address,
  output logic [data_bits-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [data_bits-1:0] lsu_out,
  output logic                 lsu_error
);

  lsu_state_t           state, state_n;
  logic                 is_read, is_read_n;
  logic                 read_valid_n, write_valid_n;
  logic [addr_bits-1:0] read_addr_n, write_addr_n;
  logic [data_bits-1:0] write_data_n, out_n;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [cnt_w-1:0] cnt, cnt_n;
  logic             err, err_n;
  assign lsu_error = err;
`else
  assign lsu_error = 1'b0;
`endif

  assign lsu_state = state;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= LSU_IDLE;
      is_read           <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt               <= '0;
      err               <= 1'b0;
`endif
    end else begin
      state             <= state_n;
      is_read           <= is_read_n;
      mem_read_valid    <= read_valid_n;
      mem_read_address  <= read_addr_n;
      mem_write_valid   <= write_valid_n;
      mem_write_address <= write_addr_n;
      mem_write_data    <= write_data_n;
      lsu_out           <= out_n;
`ifdef LSU_TIMEOUT_EN
      cnt               <= cnt_n;
      err               <= err_n;
`endif
    end
  end

  // Next-state and next-output logic; everything holds while enable is low
  always_comb begin
    state_n       = state;
    is_read_n     = is_read;
    read_valid_n  = mem_read_valid;
    read_addr_n   = mem_read_address;
    write_valid_n = mem_write_valid;
    write_addr_n  = mem_write_address;
    write_data_n  = mem_write_data;
    out_n         = lsu_out;
`ifdef LSU_TIMEOUT_EN
    cnt_n         = cnt;
    err_n         = err;
`endif
    if (enable) begin
      unique case (state)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST && (dec_mem_read_en || dec_mem_write_en)) begin
            is_read_n = dec_mem_read_en;
            state_n   = LSU_REQUESTING;
`ifdef LSU_TIMEOUT_EN
            err_n     = 1'b0;
`endif
          end
        end
        LSU_REQUESTING: begin
          if (is_read) begin
            read_valid_n = 1'b1;
            read_addr_n  = addr_bits'(rs);
          end else begin
            write_valid_n = 1'b1;
            write_addr_n  = addr_bits'(rs);
            write_data_n  = rt;
          end
`ifdef LSU_TIMEOUT_EN
          cnt_n   = '0;
`endif
          state_n = LSU_WAITING;
        end
        LSU_WAITING: begin
          if (is_read && mem_read_ready) begin
            read_valid_n = 1'b0;
            out_n        = mem_read_data;
            state_n      = LSU_DONE;
          end else if (!is_read && mem_write_ready) begin
            write_valid_n = 1'b0;
            state_n       = LSU_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          // Ready on the terminal cycle takes priority over the abort
          else if (cnt == cnt_w'(TIMEOUT_CYCLES - 1)) begin
            read_valid_n  = 1'b0;
            write_valid_n = 1'b0;
            err_n         = 1'b1;
            if (is_read) out_n = '0;
            state_n       = LSU_DONE;
          end else begin
            cnt_n = cnt + cnt_w'(1);
          end
`endif
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE) state_n = LSU_IDLE;
        end
        default: state_n = LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; timeout section runs when LSU_TIMEOUT_EN is defined.
module tb_lsu;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       dec_mem_read_en;
  logic       dec_mem_write_en;
  logic [7:0] rs;
  logic [7:0] rt;
  logic       mem_read_valid;
  logic [7:0] mem_read_address;
  logic       mem_read_ready;
  logic [7:0] mem_read_data;
  logic       mem_write_valid;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic       mem_write_ready;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int checks   = 0;
  int failures = 0;

  lsu #(
    .data_bits     (8),
    .addr_bits     (8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .core_state       (core_state),
    .dec_mem_read_en  (dec_mem_read_en),
    .dec_mem_write_en (dec_mem_write_en),
    .rs               (rs),
    .rt               (rt),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready),
    .lsu_state        (lsu_state),
    .lsu_out          (lsu_out),
    .lsu_error        (lsu_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    rs = a; rt = d; dec_mem_read_en = rd; dec_mem_write_en = wr; core_state = 3'd3;
    step();
    dec_mem_read_en = 1'b0; dec_mem_write_en = 1'b0; core_state = 3'd4;
  endtask

  task automatic finish_update();
    core_state = 3'd6;
    step();
    core_state = 3'd0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = 3'd0;
    dec_mem_read_en = 1'b0; dec_mem_write_en = 1'b0; rs = '0; rt = '0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    step(); step();
    chk("rst_state", 32'(lsu_state), 32'd0);
    chk("rst_rvalid", 32'(mem_read_valid), 32'd0);
    chk("rst_wvalid", 32'(mem_write_valid), 32'd0);
    chk("rst_addr", 32'({mem_read_address, mem_write_address, mem_write_data}), 32'd0);
    chk("rst_out", 32'(lsu_out), 32'd0);
    chk("rst_err", 32'(lsu_error), 32'd0);
    reset = 1'b0;
    step();

    // Load with ready two cycles after valid
    start_op(1'b1, 1'b0, 8'h2A, 8'h00);
    chk("ld_req_state", 32'(lsu_state), 32'd1);
    chk("ld_req_rvalid", 32'(mem_read_valid), 32'd0);
    step();
    chk("ld_wait_state", 32'(lsu_state), 32'd2);
    chk("ld_wait_rvalid", 32'(mem_read_valid), 32'd1);
    chk("ld_wait_addr", 32'(mem_read_address), 32'h2A);
    step();
    chk("ld_wait2_state", 32'(lsu_state), 32'd2);
    chk("ld_wait2_rvalid", 32'(mem_read_valid), 32'd1);
    mem_read_ready = 1'b1; mem_read_data = 8'h5C;
    step();
    mem_read_ready = 1'b0;
    chk("ld_done_state", 32'(lsu_state), 32'd3);
    chk("ld_done_rvalid", 32'(mem_read_valid), 32'd0);
    chk("ld_done_out", 32'(lsu_out), 32'h5C);
    chk("ld_done_err", 32'(lsu_error), 32'd0);
    step();
    chk("ld_hold_done", 32'(lsu_state), 32'd3);
    finish_update();
    chk("ld_idle_state", 32'(lsu_state), 32'd0);
    chk("ld_idle_out", 32'(lsu_out), 32'h5C);

    // Store with ready after four WAITING cycles
    start_op(1'b0, 1'b1, 8'h10, 8'hA5);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("st_wait_state", 32'(lsu_state), 32'd2);
      chk("st_wvalid", 32'(mem_write_valid), 32'd1);
      chk("st_waddr", 32'(mem_write_address), 32'h10);
      chk("st_wdata", 32'(mem_write_data), 32'hA5);
      chk("st_rvalid", 32'(mem_read_valid), 32'd0);
      if (i == 3) mem_write_ready = 1'b1;
      step();
    end
    mem_write_ready = 1'b0;
    chk("st_done_state", 32'(lsu_state), 32'd3);
    chk("st_done_wvalid", 32'(mem_write_valid), 32'd0);
    chk("st_done_out", 32'(lsu_out), 32'h5C);
    finish_update();
    chk("st_idle_state", 32'(lsu_state), 32'd0);

    // Both enables: read wins; ready pulse during REQUESTING is ignored
    start_op(1'b1, 1'b1, 8'h33, 8'hEE);
    chk("both_req_state", 32'(lsu_state), 32'd1);
    chk("both_req_wvalid", 32'(mem_write_valid), 32'd0);
    mem_read_ready = 1'b1; mem_read_data = 8'h11;
    step();
    mem_read_ready = 1'b0;
    chk("both_wait_state", 32'(lsu_state), 32'd2);
    chk("both_rvalid", 32'(mem_read_valid), 32'd1);
    chk("both_raddr", 32'(mem_read_address), 32'h33);
    chk("both_wvalid", 32'(mem_write_valid), 32'd0);
    chk("both_out_kept", 32'(lsu_out), 32'h5C);
    step();
    chk("both_wait2_state", 32'(lsu_state), 32'd2);
    chk("both_wvalid2", 32'(mem_write_valid), 32'd0);
    mem_read_ready = 1'b1; mem_read_data = 8'h77;
    step();
    mem_read_ready = 1'b0;
    chk("both_done_state", 32'(lsu_state), 32'd3);
    chk("both_done_out", 32'(lsu_out), 32'h77);
    chk("both_done_wvalid", 32'(mem_write_valid), 32'd0);
    finish_update();

    // enable low while WAITING with ready high: no capture until re-enabled
    start_op(1'b1, 1'b0, 8'h44, 8'h00);
    step();
    enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_hold_state", 32'(lsu_state), 32'd2);
      chk("en_hold_out", 32'(lsu_out), 32'h77);
      chk("en_hold_rvalid", 32'(mem_read_valid), 32'd1);
    end
    enable = 1'b1;
    step();
    mem_read_ready = 1'b0;
    chk("en_cap_state", 32'(lsu_state), 32'd3);
    chk("en_cap_out", 32'(lsu_out), 32'h99);
    finish_update();

    // Single-cycle ready on first WAITING cycle: DONE at the third edge
    start_op(1'b1, 1'b0, 8'h05, 8'h00);
    step();
    mem_read_ready = 1'b1; mem_read_data = 8'hE1;
    step();
    mem_read_ready = 1'b0;
    chk("fast_state", 32'(lsu_state), 32'd3);
    chk("fast_out", 32'(lsu_out), 32'hE1);
    finish_update();

`ifdef LSU_TIMEOUT_EN
    // No ready: abort after four WAITING cycles
    start_op(1'b1, 1'b0, 8'h20, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait_state", 32'(lsu_state), 32'd2);
    end
    step();
    chk("to_done_state", 32'(lsu_state), 32'd3);
    chk("to_err", 32'(lsu_error), 32'd1);
    chk("to_out", 32'(lsu_out), 32'd0);
    chk("to_rvalid", 32'(mem_read_valid), 32'd0);
    finish_update();
    start_op(1'b1, 1'b0, 8'h21, 8'h00);
    chk("to_err_clear", 32'(lsu_error), 32'd0);
    mem_read_ready = 1'b1; mem_read_data = 8'h3C;
    step();
    step();
    mem_read_ready = 1'b0;
    chk("to_recover_out", 32'(lsu_out), 32'h3C);
    finish_update();
`endif

    // Async reset mid-WAITING drops valid and state before the next edge
    start_op(1'b1, 1'b0, 8'h66, 8'h00);
    step();
    chk("ar_pre_rvalid", 32'(mem_read_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_rvalid", 32'(mem_read_valid), 32'd0);
    chk("ar_state", 32'(lsu_state), 32'd0);
    chk("ar_out", 32'(lsu_out), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("ar_idle_state", 32'(lsu_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
